cpu_hazard_scoreboard: RTL and testbench

- Parametrised successor to the pipeline hazard detector.
- Per-register scoreboard tracks in-flight writes with a per-entry latency countdown.
- Stalls IF/ID only while a source operand is not yet forwardable.
- Adds a multi-cycle-unit (mul/div) busy counter that freezes IF/ID/EX; sits beside the ID stage and drives the pipeline stall vector.

---
 rtl/cpu_hazard_scoreboard.sv | 114 +++++++++++
 tb/tb_cpu_hazard_scoreboard.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_hazard_scoreboard.sv
// Per-register write scoreboard with latency countdown plus a multi-cycle-unit busy counter.
// Optional stall performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module cpu_hazard_scoreboard #(
  parameter int REG_W  = 5,
  parameter int NUM_RD = 2,
  parameter int LAT_W  = 2,
  parameter int MC_W   = 6
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    id_valid,
  input  logic [NUM_RD*REG_W-1:0] id_rs,
  input  logic [REG_W-1:0]        id_rd,
  input  logic                    id_wr_en,
  input  logic [LAT_W-1:0]        id_lat,
  input  logic                    id_issue,
  input  logic                    mc_start,
  input  logic [MC_W-1:0]         mc_cycles,
  output logic [4:0]              stalls,
  output logic                    raw_hazard,
  output logic                    mc_busy,
  output logic [2**REG_W-1:0]     pending
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]             raw_stall_cnt,
  output logic [31:0]             mc_stall_cnt
`endif
);

  localparam int NUM_REGS  = 2**REG_W;
  localparam int STALL_IF  = 0;
  localparam int STALL_ID  = 1;
  localparam int STALL_EX  = 2;
  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

  logic [LAT_W-1:0] cnt     [NUM_REGS];
  logic [LAT_W-1:0] cnt_nxt [NUM_REGS];
  logic [MC_W-1:0]  busy_cnt;
  logic             hit;
  logic             front_stall;
  logic             issue_q;

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (id_rs[i*REG_W +: REG_W] != '0 && cnt[id_rs[i*REG_W +: REG_W]] != '0)
        hit = 1'b1;
    end
  end

  assign raw_hazard  = id_valid & hit;
  assign mc_busy     = (busy_cnt != '0);
  assign front_stall = raw_hazard | mc_busy;
  assign issue_q     = id_issue & id_valid & ~front_stall;

  always_comb begin
    stalls            = '0;
    stalls[STALL_IF]  = front_stall;
    stalls[STALL_ID]  = front_stall;
    stalls[STALL_EX]  = mc_busy;
    stalls[STALL_MEM] = 1'b0;
    stalls[STALL_WB]  = 1'b0;
  end

  // A new write never shortens an older, slower write to the same register.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - LAT_W'(1) : '0;
      if (issue_q && id_wr_en && id_rd == REG_W'(r) && r != 0 && id_lat > cnt_nxt[r])
        cnt_nxt[r] = id_lat;
    end
  end

  always_comb begin
    pending = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++)
      pending[r] = (cnt[r] != '0);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++)
        cnt[r] <= '0;
    end else if (!mc_busy) begin
      for (int unsigned r = 0; r < NUM_REGS; r++)
        cnt[r] <= cnt_nxt[r];
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      busy_cnt <= '0;
    else if (busy_cnt != '0)
      busy_cnt <= busy_cnt - MC_W'(1);
    else if (mc_start)
      busy_cnt <= mc_cycles;
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      raw_stall_cnt <= '0;
      mc_stall_cnt  <= '0;
    end else begin
      if (raw_hazard && !mc_busy && raw_stall_cnt != '1)
        raw_stall_cnt <= raw_stall_cnt + 32'd1;
      if (mc_busy && mc_stall_cnt != '1)
        mc_stall_cnt <= mc_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_hazard_scoreboard.sv
// Directed table-driven bench for cpu_hazard_scoreboard plus a mid-operation reset sequence.
module tb_cpu_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        id_valid;
  logic [4:0]  rs0, rs1;
  logic [9:0]  id_rs;
  logic [4:0]  id_rd;
  logic        id_wr_en;
  logic [1:0]  id_lat;
  logic        id_issue;
  logic        mc_start;
  logic [5:0]  mc_cycles;
  logic [4:0]  stalls;
  logic        raw_hazard;
  logic        mc_busy;
  logic [31:0] pending;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] raw_stall_cnt;
  logic [31:0] mc_stall_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  assign id_rs = {rs1, rs0};

  always #5 clk = ~clk;

  cpu_hazard_scoreboard #(.REG_W(5), .NUM_RD(2), .LAT_W(2), .MC_W(6)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rd      (id_rd),
    .id_wr_en   (id_wr_en),
    .id_lat     (id_lat),
    .id_issue   (id_issue),
    .mc_start   (mc_start),
    .mc_cycles  (mc_cycles),
    .stalls     (stalls),
    .raw_hazard (raw_hazard),
    .mc_busy    (mc_busy),
    .pending    (pending)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .raw_stall_cnt (raw_stall_cnt),
    .mc_stall_cnt  (mc_stall_cnt)
`endif
  );

  typedef struct {
    logic        v;
    logic [4:0]  rs0, rs1, rd;
    logic        we;
    logic [1:0]  lat;
    logic        iss, mcs;
    logic [5:0]  mcc;
    logic [4:0]  stl;
    logic        raw, busy;
    logic [31:0] pend;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  function automatic vec_t mk(logic v, logic [4:0] a, logic [4:0] b, logic [4:0] rd,
                              logic we, logic [1:0] lat, logic iss, logic mcs,
                              logic [5:0] mcc, logic [4:0] stl, logic raw,
                              logic busy, logic [31:0] pend);
    vec_t t;
    t.v = v; t.rs0 = a; t.rs1 = b; t.rd = rd; t.we = we; t.lat = lat;
    t.iss = iss; t.mcs = mcs; t.mcc = mcc; t.stl = stl; t.raw = raw;
    t.busy = busy; t.pend = pend;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; rs0 = t.rs0; rs1 = t.rs1; id_rd = t.rd; id_wr_en = t.we;
    id_lat = t.lat; id_issue = t.iss; mc_start = t.mcs; mc_cycles = t.mcc;
  endtask

  task automatic drive_random();
    id_valid = 1'($urandom); rs0 = 5'($urandom); rs1 = 5'($urandom);
    id_rd = 5'($urandom); id_wr_en = 1'($urandom); id_lat = 2'($urandom);
    id_issue = 1'($urandom); mc_start = 1'($urandom); mc_cycles = 6'($urandom);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " stalls"}, 32'(stalls), 32'd0);
    chk({tag, " raw"}, 32'(raw_hazard), 32'd0);
    chk({tag, " busy"}, 32'(mc_busy), 32'd0);
    chk({tag, " pending"}, pending, 32'd0);
  endtask

  initial begin
`ifdef HAZARD_PERF_CNT_EN
    int exp_raw_cnt = 0;
    int exp_mc_cnt  = 0;
`endif
    vecs[0]  = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 32'h0);
    vecs[1]  = mk(1, 0, 0,  5, 1, 2, 1, 0, 0, 5'd0, 0, 0, 32'h0);
    vecs[2]  = mk(1, 5, 0, 12, 1, 3, 1, 0, 0, 5'd3, 1, 0, 32'h20);
    vecs[3]  = mk(1, 5, 0, 12, 1, 3, 1, 0, 0, 5'd3, 1, 0, 32'h20);
    vecs[4]  = mk(1, 5, 0, 12, 1, 3, 1, 0, 0, 5'd0, 0, 0, 32'h0);
    vecs[5]  = mk(1, 0, 0,  0, 1, 3, 1, 0, 0, 5'd0, 0, 0, 32'h1000);
    vecs[6]  = mk(1, 0, 0,  7, 1, 0, 1, 0, 0, 5'd0, 0, 0, 32'h1000);
    vecs[7]  = mk(1, 0, 7,  0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 32'h1000);
    vecs[8]  = mk(1, 0, 0,  9, 1, 3, 1, 0, 0, 5'd0, 0, 0, 32'h0);
    vecs[9]  = mk(1, 0, 0,  9, 1, 1, 1, 0, 0, 5'd0, 0, 0, 32'h200);
    vecs[10] = mk(1, 9, 0,  0, 0, 0, 0, 0, 0, 5'd3, 1, 0, 32'h200);
    vecs[11] = mk(1, 9, 0,  0, 0, 0, 0, 0, 0, 5'd3, 1, 0, 32'h200);
    vecs[12] = mk(1, 9, 0,  0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 32'h0);
    vecs[13] = mk(1, 0, 0,  4, 1, 2, 1, 1, 3, 5'd0, 0, 0, 32'h0);
    vecs[14] = mk(0, 0, 0,  0, 0, 0, 0, 1, 5, 5'd7, 0, 1, 32'h10);
    vecs[15] = mk(1, 4, 0,  0, 0, 0, 0, 0, 0, 5'd7, 1, 1, 32'h10);
    vecs[16] = mk(1, 0, 0,  6, 1, 3, 1, 0, 0, 5'd7, 0, 1, 32'h10);
    vecs[17] = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 32'h10);
    vecs[18] = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 32'h10);
    vecs[19] = mk(1, 4, 0,  0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 32'h0);
    vecs[20] = mk(0, 0, 0,  0, 0, 0, 0, 1, 0, 5'd0, 0, 0, 32'h0);
    vecs[21] = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 32'h0);
    vecs[22] = mk(1, 0, 0, 10, 1, 3, 1, 0, 0, 5'd0, 0, 0, 32'h0);
    vecs[23] = mk(0, 10, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 32'h400);
    vecs[24] = mk(1, 0, 10, 11, 1, 3, 1, 0, 0, 5'd3, 1, 0, 32'h400);
    vecs[25] = mk(1, 0, 10, 0, 0, 0, 0, 0, 0, 5'd3, 1, 0, 32'h400);
    vecs[26] = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 32'h0);

    clr_n = 1'b0;
    drive(vecs[0]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_random();
      #1;
      chk_idle($sformatf("reset%0d", i));
    end
    @(negedge clk);
    drive(vecs[0]);
    clr_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk_idle($sformatf("post_reset%0d", i));
      @(negedge clk);
    end

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d stalls", i), 32'(stalls), 32'(vecs[i].stl));
      chk($sformatf("v%0d raw", i), 32'(raw_hazard), 32'(vecs[i].raw));
      chk($sformatf("v%0d busy", i), 32'(mc_busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d pending", i), pending, vecs[i].pend);
`ifdef HAZARD_PERF_CNT_EN
      if (vecs[i].raw && !vecs[i].busy) exp_raw_cnt++;
      if (vecs[i].busy) exp_mc_cnt++;
`endif
    end
    @(negedge clk);
    drive(vecs[0]);
`ifdef HAZARD_PERF_CNT_EN
    #1;
    chk("raw_stall_cnt", raw_stall_cnt, 32'(exp_raw_cnt));
    chk("mc_stall_cnt", mc_stall_cnt, 32'(exp_mc_cnt));
`endif

    // Mid-operation reset: load a pending write and a long busy period, then reset mid-cycle.
    @(negedge clk);
    drive(mk(1, 0, 0, 20, 1, 3, 1, 1, 10, 5'd0, 0, 0, 32'h0));
    @(negedge clk);
    drive(vecs[0]);
    #1;
    chk("preload pending", pending, 32'h0010_0000);
    chk("preload busy", 32'(mc_busy), 32'd1);
    chk("preload stalls", 32'(stalls), 32'd7);
    #2;
    clr_n = 1'b0;
    #1;
    chk_idle("async_reset");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_random();
      #1;
      chk_idle($sformatf("hold_reset%0d", i));
    end
    @(negedge clk);
    drive(vecs[0]);
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_idle($sformatf("after_reset%0d", i));
`ifdef HAZARD_PERF_CNT_EN
      chk($sformatf("after_reset%0d raw_cnt", i), raw_stall_cnt, 32'd0);
      chk($sformatf("after_reset%0d mc_cnt", i), mc_stall_cnt, 32'd0);
`endif
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
